issue_ctrl: RTL and testbench

- Decode-stage issue controller for the in-order RISC-V pipeline.
- Holds the IF/ID instruction register and presents the instruction to the instruction decoder.
- Tracks in-flight register writes in a countdown scoreboard and stalls issue on RAW hazards, since the pipeline has no bypass network.
- Handles the valid/ready handshakes with fetch and execute, and supports flushing on redirect.

---
 rtl/issue_ctrl.sv | 126 ++++++++++++
 tb/tb_issue_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl.sv
// issue_ctrl: decode-stage issue controller for the in-order pipeline.
//
// Holds the IF/ID instruction register, offers it to execute once it is free of
// RAW hazards, and tracks in-flight register writes in a per-register
// countdown scoreboard. The pipeline has no bypass network.
//
// Ports:
//   clk, resetn           clock (rising edge), asynchronous active-low reset
//   if_valid/if_instr/if_pc/if_ready   fetch handshake into the hold register
//   id_valid/id_instr/id_pc/ex_ready   issue handshake towards execute
//   dec_regwen, dec_rd    decoder feedback for id_instr (combinational)
//   flush                 redirect: drop held instruction and this fetch beat
//   stall_hazard          held instruction blocked by the scoreboard
//   busy_mask             per-register busy bits (bit 0 always 0)
module issue_ctrl #(
  parameter int unsigned WB_LAT = 3,
  parameter int unsigned PC_W   = 64
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            if_valid,
  input  logic [31:0]     if_instr,
  input  logic [PC_W-1:0] if_pc,
  output logic            if_ready,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [PC_W-1:0] id_pc,
  input  logic            ex_ready,
  input  logic            dec_regwen,
  input  logic [4:0]      dec_rd,
  input  logic            flush,
  output logic            stall_hazard,
  output logic [31:0]     busy_mask
);

  localparam int unsigned CntW = $clog2(WB_LAT + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(WB_LAT);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpOp32   = 7'b0111011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;

  logic            hold_valid_q;
  logic [31:0]     hold_instr_q;
  logic [PC_W-1:0] hold_pc_q;
  logic [CntW-1:0] cnt_q [1:31];

  logic [6:0]  opcode;
  logic [4:0]  rs1, rs2;
  logic        use_rs1, use_rs2;
  logic [31:0] block_mask;
  logic        hazard;
  logic        issue;

  assign opcode = hold_instr_q[6:0];
  assign rs1    = hold_instr_q[19:15];
  assign rs2    = hold_instr_q[24:20];

  always_comb begin
    use_rs1 = !((opcode == OpLui) || (opcode == OpAuipc) || (opcode == OpJal));
    use_rs2 = (opcode == OpOp) || (opcode == OpOp32) || (opcode == OpStore) ||
              (opcode == OpBranch);
  end

  // busy_mask reports every in-flight write. A reader only blocks while more
  // than one countdown cycle remains: the final cycle is the writeback cycle and
  // the register file is write-through, so the consumer reads the new value and
  // becomes eligible exactly WB_LAT cycles after the producer issued.
  always_comb begin
    busy_mask     = '0;
    block_mask    = '0;
    for (int r = 1; r < 32; r++) begin
      busy_mask[r]  = (cnt_q[r] != '0);
      block_mask[r] = (cnt_q[r] > CntOne);
    end
  end

  assign hazard       = hold_valid_q && ((use_rs1 && block_mask[rs1]) ||
                                         (use_rs2 && block_mask[rs2]));
  assign id_valid     = hold_valid_q && !hazard && !flush;
  assign stall_hazard = hold_valid_q && hazard;
  assign issue        = id_valid && ex_ready;
  // Forced low during reset so fetch never sees a beat taken while held in reset.
  assign if_ready     = resetn && !flush && (!hold_valid_q || issue);
  assign id_instr     = hold_instr_q;
  assign id_pc        = hold_pc_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_valid_q <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else if (flush) begin
      hold_valid_q <= 1'b0;
    end else if (if_valid && if_ready) begin
      hold_valid_q <= 1'b1;
      hold_instr_q <= if_instr;
      hold_pc_q    <= if_pc;
    end else if (issue) begin
      hold_valid_q <= 1'b0;
    end
  end

  // Flush leaves the scoreboard alone: older instructions are still in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 1; r < 32; r++) begin
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (issue && dec_regwen && (dec_rd == 5'(r))) begin
          cnt_q[r] <= CntLoad;
        end else if (cnt_q[r] != '0) begin
          cnt_q[r] <= cnt_q[r] - CntOne;
        end
      end
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed self-checking bench for issue_ctrl with WB_LAT=3, PC_W=64.
module tb_issue_ctrl;

  logic        clk;
  logic        resetn;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        if_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic        ex_ready;
  logic        dec_regwen;
  logic [4:0]  dec_rd;
  logic        flush;
  logic        stall_hazard;
  logic [31:0] busy_mask;

  int checks;
  int failures;

  issue_ctrl #(
    .WB_LAT(3),
    .PC_W  (64)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_ready    (if_ready),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .ex_ready    (ex_ready),
    .dec_regwen  (dec_regwen),
    .dec_rd      (dec_rd),
    .flush       (flush),
    .stall_hazard(stall_hazard),
    .busy_mask   (busy_mask)
  );

  // Minimal decoder stand-in: every opcode but STORE/BRANCH writes rd.
  assign dec_rd     = id_instr[11:7];
  assign dec_regwen = (id_instr[6:0] != 7'b0100011) && (id_instr[6:0] != 7'b1100011);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change 1ns after the edge, checks 2ns after that.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic beat(input logic v, input logic [31:0] ins, input logic [63:0] pc);
    if_valid = v;
    if_instr = ins;
    if_pc    = pc;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    ex_ready = 1'b0;
    flush    = 1'b0;
    beat(1'b0, 32'h0, 64'h0);

    // Reset state
    #2;
    check("rst_if_ready", if_ready, 0);
    check("rst_id_valid", id_valid, 0);
    check("rst_id_instr", id_instr, 0);
    check("rst_id_pc", id_pc, 0);
    check("rst_stall", stall_hazard, 0);
    check("rst_busy", busy_mask, 0);
    tick();
    tick();
    resetn = 1'b1;

    // Independent stream, back-to-back
    ex_ready = 1'b1;
    beat(1'b1, 32'h00100293, 64'h100);
    settle();
    check("ind_if_ready0", if_ready, 1);
    tick();
    beat(1'b1, 32'h00200313, 64'h104);
    settle();
    check("ind_valid1", id_valid, 1);
    check("ind_instr1", id_instr, 32'h00100293);
    check("ind_pc1", id_pc, 64'h100);
    check("ind_if_ready1", if_ready, 1);
    check("ind_stall1", stall_hazard, 0);
    tick();
    beat(1'b0, 32'h0, 64'h0);
    settle();
    check("ind_valid2", id_valid, 1);
    check("ind_instr2", id_instr, 32'h00200313);
    check("ind_stall2", stall_hazard, 0);
    check("ind_busy2", busy_mask, 32'h20);
    tick();
    settle();
    check("ind_valid3", id_valid, 0);
    check("ind_busy3", busy_mask, 32'h60);
    repeat (3) tick();
    settle();
    check("ind_drained", busy_mask, 0);

    // RAW hazard on x5
    beat(1'b1, 32'h00100293, 64'h110);
    tick();
    beat(1'b1, 32'h00128313, 64'h114);
    settle();
    check("raw_prod_valid", id_valid, 1);
    tick();
    beat(1'b0, 32'h0, 64'h0);
    settle();
    check("raw_t1_stall", stall_hazard, 1);
    check("raw_t1_valid", id_valid, 0);
    check("raw_t1_if_ready", if_ready, 0);
    check("raw_t1_busy5", busy_mask[5], 1);
    tick();
    settle();
    check("raw_t2_stall", stall_hazard, 1);
    check("raw_t2_busy5", busy_mask[5], 1);
    tick();
    settle();
    check("raw_t3_stall", stall_hazard, 0);
    check("raw_t3_valid", id_valid, 1);
    check("raw_t3_instr", id_instr, 32'h00128313);
    check("raw_t3_busy5", busy_mask[5], 1);
    tick();
    settle();
    check("raw_t4_busy", busy_mask, 32'h40);
    repeat (3) tick();

    // Unused rs1 field on LUI while x8 busy; rd=x0 writes nothing
    beat(1'b1, 32'h00100413, 64'h120);
    tick();
    beat(1'b1, 32'h123453B7, 64'h124);
    tick();
    beat(1'b0, 32'h0, 64'h0);
    settle();
    check("lui_busy8", busy_mask[8], 1);
    check("lui_stall", stall_hazard, 0);
    check("lui_valid", id_valid, 1);
    repeat (4) tick();
    settle();
    check("x0_pre_busy", busy_mask, 0);
    beat(1'b1, 32'h00100013, 64'h128);
    tick();
    beat(1'b0, 32'h0, 64'h0);
    settle();
    check("x0_valid", id_valid, 1);
    tick();
    settle();
    check("x0_busy", busy_mask, 0);

    // Backpressure
    ex_ready = 1'b0;
    beat(1'b1, 32'h00300393, 64'h200);
    tick();
    beat(1'b1, 32'h00400413, 64'h204);
    for (int i = 0; i < 4; i++) begin
      settle();
      check("bp_valid", id_valid, 1);
      check("bp_instr", id_instr, 32'h00300393);
      check("bp_pc", id_pc, 64'h200);
      check("bp_if_ready", if_ready, 0);
      tick();
    end
    ex_ready = 1'b1;
    settle();
    check("bp_release_if_ready", if_ready, 1);
    check("bp_release_valid", id_valid, 1);
    tick();
    ex_ready = 1'b0;
    beat(1'b0, 32'h0, 64'h0);
    settle();
    check("bp_next_instr", id_instr, 32'h00400413);
    check("bp_next_pc", id_pc, 64'h204);
    check("bp_busy7", busy_mask, 32'h80);
    ex_ready = 1'b1;
    tick();
    repeat (4) tick();

    // Flush while stalled on x5
    beat(1'b1, 32'h00100293, 64'h300);
    tick();
    beat(1'b1, 32'h00128313, 64'h304);
    tick();
    flush = 1'b1;
    beat(1'b1, 32'h00500493, 64'h308);
    settle();
    check("fl_if_ready", if_ready, 0);
    check("fl_valid", id_valid, 0);
    tick();
    flush = 1'b0;
    beat(1'b0, 32'h0, 64'h0);
    settle();
    check("fl_after_valid", id_valid, 0);
    check("fl_after_stall", stall_hazard, 0);
    check("fl_after_instr", id_instr, 32'h00128313);
    check("fl_after_busy", busy_mask, 32'h20);
    tick();
    settle();
    check("fl_busy_cnt1", busy_mask, 32'h20);
    tick();
    settle();
    check("fl_busy_cnt0", busy_mask, 0);

    // Reset while stalled with cnt[5]=2
    beat(1'b1, 32'h00100293, 64'h400);
    tick();
    beat(1'b1, 32'h00128313, 64'h404);
    tick();
    beat(1'b0, 32'h0, 64'h0);
    tick();
    settle();
    check("mr_pre_stall", stall_hazard, 1);
    check("mr_pre_busy", busy_mask, 32'h20);
    resetn = 1'b0;
    #1;
    check("mr_valid", id_valid, 0);
    check("mr_busy", busy_mask, 0);
    check("mr_instr", id_instr, 0);
    check("mr_if_ready", if_ready, 0);
    check("mr_stall", stall_hazard, 0);
    tick();
    settle();
    check("mr_hold_busy", busy_mask, 0);
    check("mr_hold_pc", id_pc, 0);
    resetn = 1'b1;
    settle();
    check("mr_post_if_ready", if_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
